// File: rtl/matrix_generate_3x3_8bit.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 register
// window so each incoming pixel is presented with its upper and left neighbours.
module matrix_generate_3x3_8bit #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic [7:0] per_img_Gray,
  output logic       matrix_frame_vsync,
  output logic       matrix_frame_href,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33
);

  localparam int DATA_W = 8;
  // Frame height does not shape any logic; only the line length sets buffer depth.
  localparam int LB_DEPTH = (IMG_VDISP != 10'd0) ? int'(IMG_HDISP) : int'(IMG_HDISP);

  logic [DATA_W-1:0] lb1_q [LB_DEPTH];
  logic [DATA_W-1:0] lb2_q [LB_DEPTH];
  logic [DATA_W-1:0] lb1_out;
  logic [DATA_W-1:0] lb2_out;

  logic [DATA_W-1:0] row1_p1_q, row2_p1_q, row3_p1_q;
  logic              vld_p1_q, vsync_p1_q;

  logic [DATA_W-1:0] win_p2_q [3][3];
  logic [DATA_W-1:0] win_d    [3][3];
  logic              vld_p2_q, vsync_p2_q;

  assign lb1_out = lb1_q[LB_DEPTH-1];
  assign lb2_out = lb2_q[LB_DEPTH-1];

  // Line buffers: advance only on active pixels so blanking length is irrelevant.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
    end else if (per_frame_href) begin
      lb1_q[0] <= per_img_Gray;
      lb2_q[0] <= lb1_out;
      for (int i = 1; i < LB_DEPTH; i++) begin
        lb1_q[i] <= lb1_q[i-1];
        lb2_q[i] <= lb2_q[i-1];
      end
    end
  end

  // Stage 1: register the three column taps and the strobes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      row1_p1_q  <= '0;
      row2_p1_q  <= '0;
      row3_p1_q  <= '0;
      vld_p1_q   <= 1'b0;
      vsync_p1_q <= 1'b0;
    end else begin
      row1_p1_q  <= lb2_out;
      row2_p1_q  <= lb1_out;
      row3_p1_q  <= per_img_Gray;
      vld_p1_q   <= per_frame_href;
      vsync_p1_q <= per_frame_vsync;
    end
  end

  always_comb begin
    win_d = win_p2_q;
    if (!vsync_p1_q) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_d[r][c] = '0;
        end
      end
    end else if (vld_p1_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_p2_q[r][1];
        win_d[r][1] = win_p2_q[r][2];
      end
      win_d[0][2] = row1_p1_q;
      win_d[1][2] = row2_p1_q;
      win_d[2][2] = row3_p1_q;
    end
  end

  // Stage 2: window shifts on active pixels and holds through blanking.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_p2_q[r][c] <= '0;
        end
      end
      vld_p2_q   <= 1'b0;
      vsync_p2_q <= 1'b0;
    end else begin
      win_p2_q   <= win_d;
      vld_p2_q   <= vld_p1_q;
      vsync_p2_q <= vsync_p1_q;
    end
  end

  assign matrix_frame_vsync = vsync_p2_q;
  assign matrix_frame_href  = vld_p2_q;
  assign matrix_p11 = win_p2_q[0][0];
  assign matrix_p12 = win_p2_q[0][1];
  assign matrix_p13 = win_p2_q[0][2];
  assign matrix_p21 = win_p2_q[1][0];
  assign matrix_p22 = win_p2_q[1][1];
  assign matrix_p23 = win_p2_q[1][2];
  assign matrix_p31 = win_p2_q[2][0];
  assign matrix_p32 = win_p2_q[2][1];
  assign matrix_p33 = win_p2_q[2][2];

endmodule

// File: tb/tb_matrix_generate_3x3_8bit.sv
// Bench for matrix_generate_3x3_8bit: pixel-history reference model checked every
// cycle, plus literal window values at selected pixels.
module tb_matrix_generate_3x3_8bit;

  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs, href;
  logic [7:0] gray;
  int         tag_in;

  logic       o_vs, o_hr;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_generate_3x3_8bit #(.IMG_HDISP(10'd16), .IMG_VDISP(10'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(href), .per_img_Gray(gray),
    .matrix_frame_vsync(o_vs), .matrix_frame_href(o_hr),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33)
  );

  // Reference: every accepted pixel since reset, in arrival order.
  int         hist[$];
  logic [7:0] ew [3][3];
  logic       e_vs, e_hr;
  logic       s1_vs, s1_hr;
  logic [7:0] s1_row [3];
  int         s1_tag, out_tag;
  bit         armed = 1'b0;
  bit         rst_seen;

  function automatic logic [7:0] above(int k);
    int n;
    n = hist.size();
    return (n >= k * H) ? 8'(hist[n - k * H]) : 8'd0;
  endfunction

  task automatic lit(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always begin
    logic [73:0] got, want;
    @(posedge clk);
    rst_seen = rst_n;
    if (rst_n) begin
      hist.delete();
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ew[r][c] = 8'd0;
      e_vs = 1'b0; e_hr = 1'b0; s1_vs = 1'b0; s1_hr = 1'b0;
      for (int r = 0; r < 3; r++) s1_row[r] = 8'd0;
      s1_tag = -1; out_tag = -1;
      armed = 1'b1;
    end else begin
      e_vs = s1_vs; e_hr = s1_hr; out_tag = s1_tag;
      if (!s1_vs) begin
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ew[r][c] = 8'd0;
      end else if (s1_hr) begin
        for (int r = 0; r < 3; r++) begin
          ew[r][0] = ew[r][1]; ew[r][1] = ew[r][2]; ew[r][2] = s1_row[r];
        end
      end
      s1_vs = vs; s1_hr = href; s1_tag = href ? tag_in : -1;
      s1_row[2] = gray; s1_row[1] = above(1); s1_row[0] = above(2);
      if (href) hist.push_back(int'(gray));
    end
    #1;
    if (armed) begin
      got  = {o_vs, o_hr, p11, p12, p13, p21, p22, p23, p31, p32, p33};
      want = {e_vs, e_hr, ew[0][0], ew[0][1], ew[0][2], ew[1][0], ew[1][1], ew[1][2],
              ew[2][0], ew[2][1], ew[2][2]};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL window t=%0t: got %h expected %h", $time, got, want);
      end
      if (rst_seen) lit("rst_zero", int'(got), 0);
      case (out_tag)
        10004: begin
          lit("f1_l0c4_p33", p33, 4); lit("f1_l0c4_p32", p32, 3); lit("f1_l0c4_p31", p31, 2);
          lit("f1_l0c4_upper", int'({p11, p12, p13, p21, p22, p23}), 0);
        end
        10104: begin
          lit("f1_l1c4_p23", p23, 4); lit("f1_l1c4_p13", p13, 0); lit("f1_l1c4_p33", p33, 20);
        end
        10100: begin
          lit("f1_l1c0_p33", p33, 16); lit("f1_l1c0_p32", p32, 15);
          lit("f1_l1c0_p31", p31, 14); lit("f1_l1c0_p23", p23, 0);
        end
        10205, 20205: begin
          lit("l2c5_href", o_hr, 1);
          lit("l2c5_p1x", int'({p11, p12, p13}), int'({8'd3, 8'd4, 8'd5}));
          lit("l2c5_p2x", int'({p21, p22, p23}), int'({8'd19, 8'd20, 8'd21}));
          lit("l2c5_p3x", int'({p31, p32, p33}), int'({8'd35, 8'd36, 8'd37}));
        end
        40004: begin
          lit("post_rst_upper", int'({p11, p12, p13, p21, p22, p23}), 0);
          lit("post_rst_p33", p33, 4);
        end
        default: ;
      endcase
    end
  end

  task automatic drive(logic v, logic h, logic [7:0] g, int tg);
    @(negedge clk);
    vs = v; href = h; gray = g; tag_in = tg;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, -1);
  endtask

  task automatic send_frame(int scen, int bl0, int bl1, int bl2, int bl3, bit rst_mid);
    int bl[4];
    bl = '{bl0, bl1, bl2, bl3};
    drive(1'b1, 1'b0, 8'd0, -1);
    drive(1'b1, 1'b0, 8'd0, -1);
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < H; c++) begin
        if (rst_mid && l == 2 && c == 7) begin
          @(negedge clk); rst_n = 1'b1; vs = 1'b1; href = 1'b1; gray = 8'(16 * l + c); tag_in = -1;
          drive(1'b1, 1'b0, 8'd0, -1);
          @(negedge clk); rst_n = 1'b0; vs = 1'b0; href = 1'b0; gray = 8'd0;
          idle(3);
          return;
        end
        drive(1'b1, 1'b1, 8'(16 * l + c), scen * 10000 + l * 100 + c);
      end
      for (int b = 0; b < bl[l]; b++) drive(1'b1, 1'b0, 8'd0, -1);
    end
    idle(4);
  endtask

  initial begin
    rst_n = 1'b1; vs = 1'b0; href = 1'b0; gray = 8'd0; tag_in = -1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vs = 1'($urandom); href = 1'($urandom); gray = 8'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b0; vs = 1'b0; href = 1'b0; gray = 8'd0;
    idle(4);
    send_frame(1, 3, 3, 3, 3, 1'b0);
    send_frame(2, 0, 1, 37, 0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'(200 + i), -1);
    idle(3);
    send_frame(3, 2, 2, 2, 2, 1'b1);
    send_frame(4, 2, 2, 2, 2, 1'b0);
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
